// File: rtl/odd_seq_scheduler.sv
// Round-robin scheduler sharing one odd-number generator between two burst requesters.
// Bursts are streamed on a valid/ready port tagged with the owning requester id.
module odd_seq_scheduler #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [LEN_W-1:0] req0_len,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [LEN_W-1:0] req1_len,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             out_last,
    output logic             busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] COUNT_INIT = WIDTH'(1);
    localparam logic [WIDTH-1:0] COUNT_STEP = WIDTH'(2);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             id_q, id_d;
    logic             rr_q, rr_d;

    logic             is_run;
    logic             grant0;
    logic             grant1;
    logic [LEN_W-1:0] acc_len;
    logic             last_beat;
    logic             beat_xfer;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        id_d        = id_q;
        rr_d        = rr_q;

        is_run    = (state_q == ST_RUN);
        // rr_q=0 favours requester 0 when both are valid; grants are masked while reset is held.
        grant0    = reset && !is_run && req0_valid && (!req1_valid || !rr_q);
        grant1    = reset && !is_run && req1_valid && (!req0_valid || rr_q);
        acc_len   = grant1 ? req1_len : req0_len;
        last_beat = (remaining_q == LEN_W'(1));
        beat_xfer = is_run && out_ready;

        if (grant0 || grant1) begin
            rr_d = grant0;
            if (acc_len != '0) begin
                remaining_d = acc_len;
                id_d        = grant1;
                state_d     = ST_RUN;
            end
        end

        if (beat_xfer) begin
            count_d     = count_q + COUNT_STEP;
            remaining_d = remaining_q - LEN_W'(1);
            if (last_beat) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= COUNT_INIT;
            remaining_q <= '0;
            id_q        <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign out_valid  = is_run;
    assign busy       = is_run;
    assign out_data   = is_run ? count_q : '0;
    assign out_id     = is_run ? id_q : 1'b0;
    assign out_last   = is_run ? last_beat : 1'b0;

endmodule

// File: tb/tb_odd_seq_scheduler.sv
// Scoreboard bench for odd_seq_scheduler: a reference model predicts grants and whole bursts
// at accept time; a negedge monitor checks every presented beat and the handshake outputs.
module tb_odd_seq_scheduler;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req0_valid = 1'b0;
    logic [LEN_W-1:0] req0_len = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [LEN_W-1:0] req1_len = '0;
    logic             req1_ready;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             out_last;
    logic             busy;

    odd_seq_scheduler #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_len   (req0_len),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_len   (req1_len),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit id;
        bit last;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    m_next = 1;      // next odd value the generator will issue
    bit    m_pref = 1'b0;   // requester favoured on a tie
    int    m_left = 0;      // beats of the current burst still owed
    int    rdy_mode = 0;    // 0: out_ready held high, 1: random back-pressure
    bit    final_check = 1'b0;
    bit    final_done = 1'b0;

    always @(posedge clk) begin
        #1;
        out_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    // Monitor and reference model
    always @(negedge clk) begin
        bit    idle;
        bit    e0, e1;
        int    len;
        beat_t e;
        if (!reset) begin
            checks++;
            if (out_valid || out_last || out_id || busy || out_data != 0 || req0_ready || req1_ready) begin
                errors++;
                $display("FAIL reset_outputs: got valid=%0b last=%0b id=%0b busy=%0b data=%0d r0=%0b r1=%0b, required all 0",
                         out_valid, out_last, out_id, busy, out_data, req0_ready, req1_ready);
            end
            sb.delete();
            m_next = 1;
            m_pref = 1'b0;
            m_left = 0;
        end else begin
            idle = (m_left == 0);
            checks++;
            if (out_valid !== !idle || busy !== !idle) begin
                errors++;
                $display("FAIL valid_busy: got valid=%0b busy=%0b, required %0b", out_valid, busy, !idle);
            end
            if (!idle && out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: got beat data=%0d, required no beat", out_data);
                end else begin
                    e = sb[0];
                    if (out_data !== WIDTH'(e.val) || out_id !== e.id || out_last !== e.last || out_data[0] !== 1'b1) begin
                        errors++;
                        $display("FAIL beat: got data=%0d id=%0b last=%0b, required data=%0d id=%0b last=%0b",
                                 out_data, out_id, out_last, e.val, e.id, e.last);
                    end
                    if (out_ready) begin
                        void'(sb.pop_front());
                        m_left--;
                    end
                end
            end else if (!out_valid) begin
                checks++;
                if (out_data != 0 || out_last || out_id) begin
                    errors++;
                    $display("FAIL idle_mask: got data=%0d id=%0b last=%0b, required 0 0 0", out_data, out_id, out_last);
                end
            end

            e0 = 1'b0;
            e1 = 1'b0;
            if (idle) begin
                if (req0_valid && req1_valid) begin
                    e0 = !m_pref;
                    e1 = m_pref;
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end
            checks++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                errors++;
                $display("FAIL req_ready: got r0=%0b r1=%0b, required r0=%0b r1=%0b", req0_ready, req1_ready, e0, e1);
            end
            if (e0 || e1) begin
                len = e0 ? int'(req0_len) : int'(req1_len);
                m_pref = e0;
                for (int i = 0; i < len; i++) begin
                    e.val  = m_next;
                    e.id   = e1;
                    e.last = (i == len - 1);
                    sb.push_back(e);
                    m_next = (m_next + 2) % (1 << WIDTH);
                end
                m_left = len;
            end
        end

        if (final_check && !final_done) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d beats outstanding, required 0", sb.size());
            end
            final_done = 1'b1;
        end
    end

    task automatic issue(input bit v0, input int l0, input bit v1, input int l1);
        bit a0, a1;
        req0_valid = v0;
        req0_len   = LEN_W'(l0);
        req1_valid = v1;
        req1_len   = LEN_W'(l1);
        for (int i = 0; i < 400 && (req0_valid || req1_valid); i++) begin
            a0 = req0_ready;
            a1 = req1_ready;
            @(posedge clk);
            #1;
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
        end
        if (req0_valid || req1_valid) begin
            $display("FAIL accept_timeout: got no accept within 400 cycles, required accept");
            $fatal(1, "request never accepted");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single burst, then a simultaneous pair twice
        issue(1, 3, 0, 0);
        drain();
        do_reset();
        issue(1, 2, 1, 2);
        drain();
        issue(1, 2, 1, 2);
        drain();

        // Back-pressure on a len=4 burst
        rdy_mode = 1;
        issue(0, 0, 1, 4);
        drain();
        rdy_mode = 0;

        // Wrap of the 8-bit counter over nine maximal bursts
        do_reset();
        for (int b = 0; b < 9; b++) issue(1, 15, 0, 0);
        drain();

        // Reset during beat 2 of a len=5 burst
        issue(1, 5, 0, 0);
        for (int i = 0; i < 50 && sb.size() > 4; i++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue(1, 1, 0, 0);
        drain();

        // Zero-length request consumed while the other requester waits
        do_reset();
        issue(1, 0, 1, 1);
        drain();

        // Randomized traffic with back-pressure
        rdy_mode = 1;
        for (int t = 0; t < 150; t++) begin
            bit v0, v1;
            v0 = ($urandom_range(0, 1) == 1);
            v1 = ($urandom_range(0, 1) == 1);
            if (!v0 && !v1) v0 = 1'b1;
            issue(v0, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15),
                  v1, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        rdy_mode = 0;

        final_check = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
